// File: rtl/line_buffer_pkg.sv
// Shared constants and index helpers for the sliding-window line buffer.
package line_buffer_pkg;

    localparam int EDGE_ZERO = 0;
    localparam int EDGE_REPL = 1;

    // base is the bank holding the most recently completed line
    function automatic int bank_idx(input int base, input int k, input int nbanks);
        return (base + 1 + k) % nbanks;
    endfunction

    function automatic int tap_lo(input int k, input int w);
        return k * w;
    endfunction

    function automatic int taps_bits(input int n, input int w);
        return n * w;
    endfunction

endpackage

// File: rtl/lb_ram_rf.sv
// Simple dual-port, single-clock line memory with registered read-first output.
module lb_ram_rf #(
    parameter int DATA_W = 10,
    parameter int DEPTH  = 1280,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              re,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (re) rd_data <= mem[rd_addr];
        if (we) mem[wr_addr] <= wr_data;
    end

endmodule

// File: rtl/line_buffer_nx.sv
// Sliding vertical window of NUM_TAPS lines over a Bayer stream, using
// NUM_TAPS-1 read-first line memories plus the live pixel.
module line_buffer_nx
    import line_buffer_pkg::*;
#(
    parameter int DATA_W    = 10,
    parameter int NUM_TAPS  = 7,
    parameter int LINE_W    = 1280,
    parameter int EDGE_MODE = 1
) (
    input  logic                         CCD_PIXCLK,
    input  logic                         RST,
    input  logic                         mCCD_FVAL,
    input  logic                         mCCD_LVAL,
    input  logic [DATA_W-1:0]            mCCD_DATA,
    output logic [NUM_TAPS*DATA_W-1:0]   taps_o,
    output logic                         out_valid,
    output logic                         win_full,
    output logic [$clog2(LINE_W)-1:0]    out_x,
    output logic [15:0]                  out_y,
    output logic                         overflow
);

    localparam int NB = NUM_TAPS - 1;
    localparam int XW = $clog2(LINE_W);
    localparam int CW = $clog2(LINE_W + 1);
    localparam int BW = $clog2(NB);
    localparam int FW = $clog2(NUM_TAPS);

    logic              lval_q, fval_q;
    logic [CW-1:0]     x_cnt, x_eff;
    logic [BW-1:0]     wp, wp_eff, wp_q;
    logic [FW-1:0]     filled, filled_eff, filled_q;
    logic [15:0]       y_cnt, y_eff;
    logic [DATA_W-1:0] live_q;
    logic              fval_rise, lval_fall, accept, drop;

    // A frame start overrides the counters for the pixel arriving with it.
    assign fval_rise  = mCCD_FVAL & ~fval_q;
    assign lval_fall  = lval_q & ~mCCD_LVAL;
    assign x_eff      = fval_rise ? '0 : x_cnt;
    assign wp_eff     = fval_rise ? '0 : wp;
    assign filled_eff = fval_rise ? '0 : filled;
    assign y_eff      = fval_rise ? '0 : y_cnt;
    assign accept     = mCCD_LVAL && (x_eff < CW'(LINE_W));
    assign drop       = mCCD_LVAL && !accept;

    always_ff @(posedge CCD_PIXCLK or posedge RST) begin
        if (RST) begin
            lval_q   <= 1'b0;
            fval_q   <= 1'b0;
            x_cnt    <= '0;
            wp       <= '0;
            filled   <= '0;
            y_cnt    <= '0;
            overflow <= 1'b0;
        end else begin
            lval_q <= mCCD_LVAL;
            fval_q <= mCCD_FVAL;
            if (drop) overflow <= 1'b1;
            if (fval_rise) begin
                wp     <= '0;
                filled <= '0;
                y_cnt  <= '0;
                x_cnt  <= accept ? CW'(1) : '0;
            end else if (lval_fall) begin
                x_cnt <= '0;
                wp    <= (wp == BW'(NB - 1)) ? '0 : wp + BW'(1);
                y_cnt <= y_cnt + 16'd1;
                if (filled != FW'(NB)) filled <= filled + FW'(1);
            end else if (accept) begin
                x_cnt <= x_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge CCD_PIXCLK or posedge RST) begin
        if (RST) begin
            out_valid <= 1'b0;
            win_full  <= 1'b0;
            out_x     <= '0;
            out_y     <= '0;
            live_q    <= '0;
            wp_q      <= '0;
            filled_q  <= '0;
        end else begin
            out_valid <= accept;
            if (accept) begin
                win_full <= (filled_eff == FW'(NB));
                out_x    <= x_eff[XW-1:0];
                out_y    <= y_eff;
                live_q   <= mCCD_DATA;
                wp_q     <= wp_eff;
                filled_q <= filled_eff;
            end
        end
    end

    logic [DATA_W-1:0] rd [NB];

    for (genvar b = 0; b < NB; b++) begin : g_bank
        lb_ram_rf #(.DATA_W(DATA_W), .DEPTH(LINE_W)) u_ram (
            .clk     (CCD_PIXCLK),
            .we      (accept && (wp_eff == BW'(b))),
            .wr_addr (x_eff[XW-1:0]),
            .wr_data (mCCD_DATA),
            .re      (accept),
            .rd_addr (x_eff[XW-1:0]),
            .rd_data (rd[b])
        );
    end

    logic [DATA_W-1:0] raw [NUM_TAPS];
    logic [BW-1:0]     prev;
    logic [FW-1:0]     ridx;

    // Bank wp_q (being overwritten) returns the oldest line, so it feeds tap 0.
    always_comb begin
        prev = (wp_q == '0) ? BW'(NB - 1) : wp_q - BW'(1);
        ridx = FW'(NB) - filled_q;
        for (int k = 0; k < NB; k++)
            raw[k] = rd[BW'(bank_idx(int'(prev), k, NB))];
        raw[NB] = live_q;
        taps_o = '0;
        if (out_valid) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                if (k < NB - int'(filled_q))
                    taps_o[tap_lo(k, DATA_W) +: DATA_W] = (EDGE_MODE == EDGE_REPL) ? raw[ridx] : '0;
                else
                    taps_o[tap_lo(k, DATA_W) +: DATA_W] = raw[k];
            end
        end
    end

endmodule
